id_ex_pipe_reg: RTL and testbench
=================================

ID_EX_PIPE_REG -- requirements
Module: id_ex_pipe_reg

Interface
REQ-001 Parameter DATA_WIDTH, default 32, sets the operand/immediate datapath width.
REQ-002 Parameter REG_ADDR_WIDTH, default 4, sets the destination register index width (16 ARM registers).
REQ-003 The block SHALL use one clock and a synchronous, active-high reset; clock is clk and reset is reset, and no other clock or async reset exists.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 stall  input  1  hold all stage contents.
REQ-007 flush  input  1  replace next stage contents with a bubble.
REQ-008 valid_in  input  1  decode slot holds a real instruction (same signal that selects the control mux).
REQ-009 reg_write_enable_in / reg_write_enable_out  in/out  1  register write enable.
REQ-010 mem_write_enable_in / mem_write_enable_out  in/out  1  memory write enable.
REQ-011 mem_to_reg_select_in / mem_to_reg_select_out  in/out  1  writeback source select.
REQ-012 alu_src_select_in / alu_src_select_out  in/out  1  ALU operand-B select.
REQ-013 status_bits_in / status_bits_out  in/out  1  update-flags (S bit).
REQ-014 alu_control_in / alu_control_out  in/out  2  ALU operation.
REQ-015 pc_src_select_in / pc_src_select_out  in/out  1  PC source select.
REQ-016 rn_data_in / rn_data_out  in/out  DATA_WIDTH  operand A.
REQ-017 rm_data_in / rm_data_out  in/out  DATA_WIDTH  operand B register value.
REQ-018 imm_in / imm_out  in/out  DATA_WIDTH  extended immediate.
REQ-019 rd_addr_in / rd_addr_out  in/out  REG_ADDR_WIDTH  destination register.
REQ-020 valid_out  output  1  execute slot holds a real instruction.
REQ-021 bubble_count  output  16  bubbles injected (present only with ID_EX_BUBBLE_COUNT_EN).

Function
REQ-022 Latency SHALL be exactly one cycle: inputs sampled at rising clk edge appear on outputs after that edge.
REQ-023 Per-edge priority SHALL be reset > flush > stall > load.
REQ-024 Load (no reset/flush/stall): all *_out take *_in, valid_out takes valid_in.
REQ-025 Load with valid_in=0: all seven control outputs and valid_out SHALL be 0 regardless of control inputs; data outputs load normally.
REQ-026 Stall: every output, including bubble_count, SHALL hold its value.
REQ-027 Flush: control outputs, valid_out and all data outputs SHALL become 0; flush with stall asserted SHALL still flush.
REQ-028 Outputs SHALL be driven only by registers; no combinational input-to-output path.

Reset
REQ-029 On reset, every output (controls, data, rd_addr_out, valid_out, bubble_count) SHALL be 0 at the next edge.
REQ-030 Reset asserted mid-stall or with flush SHALL override both; first edge after deassertion is a normal load/stall/flush.

Configuration
REQ-031 Macro ID_EX_BUBBLE_COUNT_EN defined: bubble_count port exists, increments by 1 on each non-reset edge that is a flush or a load with valid_in=0, saturates at 16'hFFFF, holds on stall.
REQ-032 Macro undefined: bubble_count port and counter logic SHALL be absent; all other behaviour identical.

Structure
REQ-033 Shared package id_ex_pkg SHALL hold the control-bundle typedef (seven control fields), ALU_CTL_WIDTH=2, BUBBLE_CNT_WIDTH=16.
REQ-034 One sub-module, sat_counter (BUBBLE_CNT_WIDTH wide, enable + sync reset, saturating), SHALL implement the counter, instantiated only under ID_EX_BUBBLE_COUNT_EN.

Verification
REQ-035 Reset 2 cycles with all inputs 1 -> all outputs 0, bubble_count=0.
REQ-036 valid_in=1, alu_control_in=2'b10, rn_data_in=32'h0000_00AA, rd_addr_in=4'h3 -> next edge alu_control_out=2'b10, rn_data_out=32'h0000_00AA, rd_addr_out=4'h3, valid_out=1.
REQ-037 Loaded state then stall=1 for 3 cycles with changing inputs -> outputs unchanged all 3 cycles; bubble_count unchanged.
REQ-038 valid_in=0, all control inputs 1 -> controls and valid_out 0, bubble_count +1; then flush=1 with stall=1 -> all outputs 0, bubble_count +1.
REQ-039 bubble_count preloaded to 16'hFFFE via 65534 bubbles, 3 more bubbles -> 16'hFFFF, holds.
REQ-040 Build without ID_EX_BUBBLE_COUNT_EN -> REQ-035..038 pass, bubble_count absent.

Source files
------------

// File: rtl/id_ex_pkg.sv
// id_ex_pkg: shared control-bundle type and widths for the ID/EX pipeline register
package id_ex_pkg;
  localparam int ALU_CTL_WIDTH = 2;
  localparam int BUBBLE_CNT_WIDTH = 16;
  typedef struct packed {
    logic                     reg_write;
    logic                     mem_write;
    logic                     mem_to_reg;
    logic                     alu_src;
    logic                     status_bits;
    logic [ALU_CTL_WIDTH-1:0] alu_control;
    logic                     pc_src;
  } ctl_t;
endpackage

// File: rtl/id_ex_pipe_reg_sat_counter.sv
// sat_counter: enable-driven up-counter with sync reset that sticks at all-ones
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  output logic [W-1:0] o_count
);
  logic [W-1:0] r_count;
  always_ff @(posedge clk)
    if (rst) r_count <= '0;
    else if (i_en && !(&r_count)) r_count <= r_count + 1'b1;
  assign o_count = r_count;
endmodule

// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: ID/EX pipeline register with stall/flush; ID_EX_BUBBLE_COUNT_EN adds a bubble counter
module id_ex_pipe_reg
  import id_ex_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      valid_in,
  input  logic                      reg_write_enable_in,
  input  logic                      mem_write_enable_in,
  input  logic                      mem_to_reg_select_in,
  input  logic                      alu_src_select_in,
  input  logic                      status_bits_in,
  input  logic [ALU_CTL_WIDTH-1:0]  alu_control_in,
  input  logic                      pc_src_select_in,
  input  logic [DATA_WIDTH-1:0]     rn_data_in,
  input  logic [DATA_WIDTH-1:0]     rm_data_in,
  input  logic [DATA_WIDTH-1:0]     imm_in,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr_in,
  output logic                      reg_write_enable_out,
  output logic                      mem_write_enable_out,
  output logic                      mem_to_reg_select_out,
  output logic                      alu_src_select_out,
  output logic                      status_bits_out,
  output logic [ALU_CTL_WIDTH-1:0]  alu_control_out,
  output logic                      pc_src_select_out,
  output logic [DATA_WIDTH-1:0]     rn_data_out,
  output logic [DATA_WIDTH-1:0]     rm_data_out,
  output logic [DATA_WIDTH-1:0]     imm_out,
  output logic [REG_ADDR_WIDTH-1:0] rd_addr_out,
  output logic                      valid_out
`ifdef ID_EX_BUBBLE_COUNT_EN
  ,
  output logic [BUBBLE_CNT_WIDTH-1:0] bubble_count
`endif
);
  ctl_t                      w_ctl_in;
  ctl_t                      r_ctl;
  logic                      r_valid;
  logic [DATA_WIDTH-1:0]     r_rn, r_rm, r_imm;
  logic [REG_ADDR_WIDTH-1:0] r_rd;
  assign w_ctl_in = '{reg_write: reg_write_enable_in, mem_write: mem_write_enable_in,
                      mem_to_reg: mem_to_reg_select_in, alu_src: alu_src_select_in,
                      status_bits: status_bits_in, alu_control: alu_control_in,
                      pc_src: pc_src_select_in};
  always_ff @(posedge clk)
    if (reset || flush) begin
      r_ctl   <= '0;
      r_valid <= 1'b0;
      r_rn    <= '0;
      r_rm    <= '0;
      r_imm   <= '0;
      r_rd    <= '0;
    end else if (!stall) begin
      r_ctl   <= valid_in ? w_ctl_in : '0;
      r_valid <= valid_in;
      r_rn    <= rn_data_in;
      r_rm    <= rm_data_in;
      r_imm   <= imm_in;
      r_rd    <= rd_addr_in;
    end
  assign reg_write_enable_out  = r_ctl.reg_write;
  assign mem_write_enable_out  = r_ctl.mem_write;
  assign mem_to_reg_select_out = r_ctl.mem_to_reg;
  assign alu_src_select_out    = r_ctl.alu_src;
  assign status_bits_out       = r_ctl.status_bits;
  assign alu_control_out       = r_ctl.alu_control;
  assign pc_src_select_out     = r_ctl.pc_src;
  assign rn_data_out           = r_rn;
  assign rm_data_out           = r_rm;
  assign imm_out               = r_imm;
  assign rd_addr_out           = r_rd;
  assign valid_out             = r_valid;
`ifdef ID_EX_BUBBLE_COUNT_EN
  // A bubble is a flush, or an unstalled load of an empty decode slot
  logic w_bubble;
  assign w_bubble = flush || (!stall && !valid_in);
  sat_counter #(.W(BUBBLE_CNT_WIDTH)) u_bubble_cnt (
    .clk    (clk),
    .rst    (reset),
    .i_en   (w_bubble),
    .o_count(bubble_count)
  );
`endif
endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb_id_ex_pipe_reg: directed bench with a cycle model; ID_EX_BUBBLE_COUNT_EN enables counter checks
module tb_id_ex_pipe_reg;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset, stall, flush, valid_in;
  logic rwe_i, mwe_i, m2r_i, as_i, sb_i, pcs_i;
  logic [1:0] alu_i;
  logic [31:0] rn_i, rm_i, imm_i;
  logic [3:0] rd_i;
  logic rwe_o, mwe_o, m2r_o, as_o, sb_o, pcs_o, valid_out;
  logic [1:0] alu_o;
  logic [31:0] rn_o, rm_o, imm_o;
  logic [3:0] rd_o;
  logic [15:0] bc_o;
`ifdef ID_EX_BUBBLE_COUNT_EN
  logic [15:0] bubble_count;
  assign bc_o = bubble_count;
`else
  assign bc_o = 16'h0;
`endif
  id_ex_pipe_reg dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .valid_in(valid_in),
    .reg_write_enable_in(rwe_i), .mem_write_enable_in(mwe_i), .mem_to_reg_select_in(m2r_i),
    .alu_src_select_in(as_i), .status_bits_in(sb_i), .alu_control_in(alu_i),
    .pc_src_select_in(pcs_i), .rn_data_in(rn_i), .rm_data_in(rm_i), .imm_in(imm_i),
    .rd_addr_in(rd_i),
    .reg_write_enable_out(rwe_o), .mem_write_enable_out(mwe_o), .mem_to_reg_select_out(m2r_o),
    .alu_src_select_out(as_o), .status_bits_out(sb_o), .alu_control_out(alu_o),
    .pc_src_select_out(pcs_o), .rn_data_out(rn_o), .rm_data_out(rm_o), .imm_out(imm_o),
    .rd_addr_out(rd_o), .valid_out(valid_out)
`ifdef ID_EX_BUBBLE_COUNT_EN
    , .bubble_count(bubble_count)
`endif
  );
  logic [7:0] ctl_o;
  assign ctl_o = {rwe_o, mwe_o, m2r_o, as_o, sb_o, alu_o, pcs_o};
  int errors = 0;
  int checks = 0;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      if (errors <= 30) $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  task automatic set_ctl(input logic [7:0] c);
    {rwe_i, mwe_i, m2r_i, as_i, sb_i, alu_i, pcs_i} = c;
  endtask
  // Reference model: what the execute slot must hold after each edge
  logic [7:0] m_ctl;
  logic m_v;
  logic [31:0] m_rn, m_rm, m_imm;
  logic [3:0] m_rd;
  int m_bc;
  bit m_ok = 0;
  always @(posedge clk) begin
    if (reset) begin
      {m_ctl, m_v, m_rn, m_rm, m_imm, m_rd} = '0;
      m_bc = 0;
      m_ok = 1;
    end else if (flush) begin
      {m_ctl, m_v, m_rn, m_rm, m_imm, m_rd} = '0;
      m_bc = (m_bc + 1 > 65535) ? 65535 : m_bc + 1;
    end else if (!stall) begin
      m_ctl = valid_in ? {rwe_i, mwe_i, m2r_i, as_i, sb_i, alu_i, pcs_i} : 8'h0;
      m_v = valid_in;
      m_rn = rn_i;
      m_rm = rm_i;
      m_imm = imm_i;
      m_rd = rd_i;
      if (!valid_in) m_bc = (m_bc + 1 > 65535) ? 65535 : m_bc + 1;
    end
  end
  always @(negedge clk)
    if (m_ok) begin
      chk("model_ctl", {56'h0, ctl_o}, {56'h0, m_ctl});
      chk("model_valid", {63'h0, valid_out}, {63'h0, m_v});
      chk("model_rn", {32'h0, rn_o}, {32'h0, m_rn});
      chk("model_rm", {32'h0, rm_o}, {32'h0, m_rm});
      chk("model_imm", {32'h0, imm_o}, {32'h0, m_imm});
      chk("model_rd", {60'h0, rd_o}, {60'h0, m_rd});
`ifdef ID_EX_BUBBLE_COUNT_EN
      chk("model_bc", {48'h0, bc_o}, 64'(m_bc));
`endif
    end
  initial begin
    reset = 1; stall = 1; flush = 1; valid_in = 1; set_ctl(8'hFF);
    rn_i = '1; rm_i = '1; imm_i = '1; rd_i = '1;
    repeat (2) @(negedge clk);
    chk("rst_ctl", {56'h0, ctl_o}, 64'h0);
    chk("rst_valid", {63'h0, valid_out}, 64'h0);
    chk("rst_data", {rn_o, rm_o | imm_o}, 64'h0);
    chk("rst_rd", {60'h0, rd_o}, 64'h0);
    chk("rst_bc", {48'h0, bc_o}, 64'h0);
    reset = 0; stall = 0; flush = 0; valid_in = 1; set_ctl(8'b0000_0100);
    rn_i = 32'hAA; rm_i = 32'h55; imm_i = 32'h1234; rd_i = 4'h3;
    @(negedge clk);
    chk("load_alu", {62'h0, alu_o}, 64'h2);
    chk("load_rn", {32'h0, rn_o}, 64'hAA);
    chk("load_rd", {60'h0, rd_o}, 64'h3);
    chk("load_valid", {63'h0, valid_out}, 64'h1);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      set_ctl(8'(8'h5A + i)); rn_i = 32'hDEAD_0000 + i; rd_i = 4'(9 + i); valid_in = i[0];
      @(negedge clk);
      chk("stall_alu", {62'h0, alu_o}, 64'h2);
      chk("stall_rn", {32'h0, rn_o}, 64'hAA);
      chk("stall_rd", {60'h0, rd_o}, 64'h3);
      chk("stall_bc", {48'h0, bc_o}, 64'h0);
    end
    stall = 0; valid_in = 0; set_ctl(8'hFF); rn_i = 32'h11;
    @(negedge clk);
    chk("empty_ctl", {56'h0, ctl_o}, 64'h0);
    chk("empty_valid", {63'h0, valid_out}, 64'h0);
    chk("empty_rn", {32'h0, rn_o}, 64'h11);
`ifdef ID_EX_BUBBLE_COUNT_EN
    chk("empty_bc", {48'h0, bc_o}, 64'h1);
`endif
    flush = 1; stall = 1; valid_in = 1;
    @(negedge clk);
    chk("flush_ctl", {56'h0, ctl_o}, 64'h0);
    chk("flush_rn", {32'h0, rn_o}, 64'h0);
    chk("flush_valid", {63'h0, valid_out}, 64'h0);
`ifdef ID_EX_BUBBLE_COUNT_EN
    chk("flush_bc", {48'h0, bc_o}, 64'h2);
`endif
    flush = 0; stall = 0; valid_in = 1; set_ctl(8'hFF); rn_i = 32'hCAFE_F00D; rd_i = 4'hF;
    @(negedge clk);
    chk("full_ctl", {56'h0, ctl_o}, 64'hFF);
    chk("full_rd", {60'h0, rd_o}, 64'hF);
    stall = 1; reset = 1;
    @(negedge clk);
    chk("rst_stall_ctl", {56'h0, ctl_o}, 64'h0);
    chk("rst_stall_rn", {32'h0, rn_o}, 64'h0);
    reset = 0;
    @(negedge clk);
    chk("post_rst_hold", {32'h0, rn_o}, 64'h0);
`ifdef ID_EX_BUBBLE_COUNT_EN
    stall = 0; valid_in = 0;
    repeat (65534) @(negedge clk);
    chk("sat_fffe", {48'h0, bc_o}, 64'hFFFE);
    repeat (3) @(negedge clk);
    chk("sat_ffff", {48'h0, bc_o}, 64'hFFFF);
    flush = 1;
    @(negedge clk);
    chk("sat_hold", {48'h0, bc_o}, 64'hFFFF);
    flush = 0;
`endif
    stall = 0; valid_in = 1; set_ctl(8'h81); rn_i = 32'h1; rm_i = 32'h2; imm_i = 32'h3; rd_i = 4'h4;
    @(negedge clk);
    chk("final_ctl", {56'h0, ctl_o}, 64'h81);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
